// File: rtl/csr_trap_unit.sv
// csr_trap_unit: M-mode CSR file, irq synchronisers and trap/mret sequencing; reads and redirect are same-cycle, never stalls.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters (with high halves when XLEN=32).
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'('h1800),
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter int              SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wsrc,
  input  logic            src_zero,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal,
  output logic            trap_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'('h1888);
  localparam logic [XLEN-1:0] MSTATUS_MPP   = XLEN'('h1800);
  localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'('h880);
  localparam logic [XLEN-1:0] ALIGN_MASK    = ~XLEN'(3);
  localparam int              MIE_BIT       = 3;
  localparam int              MPIE_BIT      = 7;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic [SYNC_STAGES-1:0] tmr_sync_q, tmr_sync_d;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] rd_val;
  logic            csr_known;
  logic [XLEN-1:0] wr_val;
  logic            wr_req;
  logic            irq_pend;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic            do_ecall;
  logic            do_mret;
  logic            do_write;
  logic [XLEN-1:0] mtvec_base;

  // Shift-in synchronisers; the MSB is the level software sees in mip.
  always_comb begin
    ext_sync_d = (ext_sync_q << 1) | SYNC_STAGES'(irq_ext);
    tmr_sync_d = (tmr_sync_q << 1) | SYNC_STAGES'(irq_timer);
    mip_val    = XLEN'({ext_sync_q[SYNC_STAGES-1], 3'b000, tmr_sync_q[SYNC_STAGES-1], 7'b0000000});
  end

  always_comb begin
    rd_val    = '0;
    csr_known = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:  rd_val = mstatus_q | MSTATUS_MPP;
      ADDR_MIE:      rd_val = mie_q;
      ADDR_MTVEC:    rd_val = mtvec_q;
      ADDR_MSCRATCH: rd_val = mscratch_q;
      ADDR_MEPC:     rd_val = mepc_q;
      ADDR_MCAUSE:   rd_val = mcause_q;
      ADDR_MIP:      rd_val = mip_val;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   rd_val = mcycle_q[XLEN-1:0];
      ADDR_MINSTRET: rd_val = minstret_q[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) rd_val = XLEN'(mcycle_q[63:32]);
        else            csr_known = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (XLEN == 32) rd_val = XLEN'(minstret_q[63:32]);
        else            csr_known = 1'b0;
      end
`else
      ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MCYCLEH, ADDR_MINSTRETH: csr_known = 1'b0;
`endif
      default:       csr_known = 1'b0;
    endcase
  end

  // op[1:0]: 01 write, 10 set, 11 clear; op[1] marks the set/clear family.
  always_comb begin
    case (csr_op[1:0])
      2'b01:   wr_val = csr_wsrc;
      2'b10:   wr_val = rd_val | csr_wsrc;
      2'b11:   wr_val = rd_val & ~csr_wsrc;
      default: wr_val = rd_val;
    endcase
    wr_req = valid & (csr_op[1:0] != 2'b00) & csr_known & ~(csr_op[1] & src_zero);
  end

  always_comb begin
    irq_pend   = mstatus_q[MIE_BIT] &
                 ((mie_q[11] & mip_val[11]) | (mie_q[7] & mip_val[7]));
    irq_take   = valid & irq_pend;
    irq_code   = (mie_q[11] & mip_val[11]) ? 4'd11 : 4'd7;
    do_ecall   = valid & ecall & ~irq_take;
    do_mret    = valid & mret & ~irq_take & ~ecall;
    do_write   = wr_req & ~irq_take & ~ecall & ~mret;
    mtvec_base = mtvec_q & ALIGN_MASK;
  end

  always_comb begin
    csr_rdata   = rd_val;
    illegal     = valid & (csr_op != 3'b000) & ~csr_known;
    trap_taken  = irq_take | do_ecall;
    redirect    = irq_take | do_ecall | do_mret;
    redirect_pc = '0;
    if (irq_take) begin
      redirect_pc = (mtvec_q[1:0] == 2'b01) ? mtvec_base + XLEN'({irq_code, 2'b00}) : mtvec_base;
    end else if (do_ecall) begin
      redirect_pc = mtvec_base;
    end else if (do_mret) begin
      redirect_pc = mepc_q;
    end
  end

  // Only one of trap entry, mret or a CSR write lands in any cycle.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (irq_take | do_ecall) begin
      mepc_d              = pc & ALIGN_MASK;
      mcause_d            = irq_take ? {1'b1, {(XLEN-5){1'b0}}, irq_code} : XLEN'(11);
      mstatus_d[MPIE_BIT] = mstatus_q[MIE_BIT];
      mstatus_d[MIE_BIT]  = 1'b0;
    end else if (do_mret) begin
      mstatus_d[MIE_BIT]  = mstatus_q[MPIE_BIT];
      mstatus_d[MPIE_BIT] = 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        ADDR_MSTATUS:  mstatus_d  = wr_val & MSTATUS_WMASK;
        ADDR_MIE:      mie_d      = wr_val & MIE_WMASK;
        ADDR_MTVEC:    mtvec_d    = wr_val;
        ADDR_MSCRATCH: mscratch_d = wr_val;
        ADDR_MEPC:     mepc_d     = wr_val & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_d   = wr_val;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= MSTATUS_RST & MSTATUS_WMASK;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      ext_sync_q <= '0;
      tmr_sync_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      ext_sync_q <= ext_sync_d;
      tmr_sync_q <= tmr_sync_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A software write replaces the whole counter for that cycle, including the increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = (valid & ~irq_take & ~ecall) ? minstret_q + 64'd1 : minstret_q;
    if (do_write) begin
      case (csr_addr)
        ADDR_MCYCLE: begin
          if (XLEN == 32) mcycle_d = {mcycle_q[63:32], wr_val[31:0]};
          else            mcycle_d = 64'(wr_val);
        end
        ADDR_MINSTRET: begin
          if (XLEN == 32) minstret_d = {minstret_q[63:32], wr_val[31:0]};
          else            minstret_d = 64'(wr_val);
        end
        ADDR_MCYCLEH:   mcycle_d   = {wr_val[31:0], mcycle_q[31:0]};
        ADDR_MINSTRETH: minstret_d = {wr_val[31:0], minstret_q[31:0]};
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed vector table, async-reset sequence, then random traffic against a CSR-level model.
module tb_csr_trap_unit;
  localparam int XLEN = 32;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wsrc;
  logic            src_zero, ecall, mret;
  logic [XLEN-1:0] pc;
  logic            irq_ext, irq_timer;
  logic [XLEN-1:0] csr_rdata, redirect_pc;
  logic            illegal, trap_taken, redirect;

  csr_trap_unit #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .valid(valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wsrc(csr_wsrc), .src_zero(src_zero), .ecall(ecall), .mret(mret), .pc(pc),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .csr_rdata(csr_rdata), .illegal(illegal),
    .trap_taken(trap_taken), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic v; logic [2:0] op; logic [11:0] a; logic [XLEN-1:0] w; logic sz, ec, mr;
    logic [XLEN-1:0] p; logic ie;
    logic [XLEN-1:0] e_rd; logic e_ill, e_trap, e_red; logic [XLEN-1:0] e_rpc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic [2:0] op, input logic [11:0] a,
                              input logic [XLEN-1:0] w, input logic sz, ec, mr,
                              input logic [XLEN-1:0] p, input logic ie, input logic [XLEN-1:0] erd,
                              input logic eil, etr, ere, input logic [XLEN-1:0] erp);
    vec_t t;
    t.v = v; t.op = op; t.a = a; t.w = w; t.sz = sz; t.ec = ec; t.mr = mr; t.p = p; t.ie = ie;
    t.e_rd = erd; t.e_ill = eil; t.e_trap = etr; t.e_red = ere; t.e_rpc = erp;
    tbl.push_back(t);
  endfunction

  task automatic idle();
    valid = 0; csr_op = 0; csr_addr = 12'h300; csr_wsrc = 0; src_zero = 1;
    ecall = 0; mret = 0; pc = 0; irq_ext = 0; irq_timer = 0;
  endtask

  // ---------------- reference model: CSR contents by name, irq delay as a queue
  logic [XLEN-1:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  bit ext_h[$], tim_h[$];

  task automatic m_reset();
    m_mstatus = 'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    ext_h = {}; tim_h = {};
    for (int i = 0; i < SYNC; i++) begin ext_h.push_back(1'b0); tim_h.push_back(1'b0); end
  endtask

  function automatic logic [XLEN-1:0] m_mip();
    return (ext_h[0] ? 'h800 : 0) | (tim_h[0] ? 'h80 : 0);
  endfunction

  function automatic bit m_take();
    return valid && m_mstatus[3] && ((m_mie & m_mip()) != 0);
  endfunction

  function automatic int m_cause();
    return ((m_mie & m_mip() & 'h800) != 0) ? 11 : 7;
  endfunction

  task automatic m_read(input logic [11:0] a, output bit ok, output logic [XLEN-1:0] v);
    ok = 1;
    case (a)
      12'h300: v = (m_mstatus & 'h88) | 'h1800;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc & ~32'h3;
      12'h342: v = m_mcause;
      12'h344: v = m_mip();
      default: begin ok = 0; v = 0; end
    endcase
  endtask

  task automatic m_eval(output logic [XLEN-1:0] rd, output logic ill, trap, red, output logic [XLEN-1:0] rpc);
    bit ok;
    logic [XLEN-1:0] base;
    m_read(csr_addr, ok, rd);
    base = m_mtvec & ~32'h3;
    ill  = valid && csr_op != 0 && !ok;
    trap = m_take() || (valid && ecall);
    red  = trap || (valid && mret);
    if (m_take())             rpc = (m_mtvec[1:0] == 2'b01) ? base + 4 * m_cause() : base;
    else if (valid && ecall)  rpc = base;
    else if (valid && mret)   rpc = m_mepc & ~32'h3;
    else                      rpc = 0;
  endtask

  task automatic m_commit();
    bit ok;
    logic [XLEN-1:0] old, nv;
    m_read(csr_addr, ok, old);
    if (m_take() || (valid && ecall)) begin
      m_mepc   = pc;
      m_mcause = m_take() ? ((XLEN'(1) << (XLEN-1)) | XLEN'(m_cause())) : XLEN'(11);
      m_mstatus[7] = m_mstatus[3];
      m_mstatus[3] = 1'b0;
    end else if (valid && mret) begin
      m_mstatus[3] = m_mstatus[7];
      m_mstatus[7] = 1'b1;
    end else if (valid && ok && csr_op[1:0] != 0 && !(csr_op[1] && src_zero)) begin
      case (csr_op[1:0])
        2'b01:   nv = csr_wsrc;
        2'b10:   nv = old | csr_wsrc;
        default: nv = old & ~csr_wsrc;
      endcase
      case (csr_addr)
        12'h300: m_mstatus  = nv;
        12'h304: m_mie      = nv & 'h880;
        12'h305: m_mtvec    = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv;
        12'h342: m_mcause   = nv;
        default: ;
      endcase
    end
    ext_h.push_back(irq_ext);   void'(ext_h.pop_front());
    tim_h.push_back(irq_timer); void'(tim_h.pop_front());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] addrs[10];
    logic [XLEN-1:0] e_rd, e_rpc;
    logic e_ill, e_trap, e_red;
    logic [2:0] ops[7];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'hF14, 12'h300};
    ops   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    //   v op  addr    wsrc          sz ec mr pc            ie  rdata         il tr rd rpc
    add(1, 2, 12'h300, 0,            1, 0, 0, 0,            0, 32'h1800,     0, 0, 0, 0);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            0, 32'h1800,     0, 0, 0, 0);
    add(1, 1, 12'h305, 32'h80000101, 0, 0, 0, 0,            0, 0,            0, 0, 0, 0);
    add(1, 1, 12'h304, 32'h880,      0, 0, 0, 0,            0, 0,            0, 0, 0, 0);
    add(1, 2, 12'h300, 32'h8,        0, 0, 0, 0,            0, 32'h1800,     0, 0, 0, 0);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            1, 32'h1808,     0, 0, 0, 0);
    add(0, 0, 12'h344, 0,            0, 0, 0, 0,            1, 0,            0, 0, 0, 0);
    add(1, 0, 12'h344, 0,            0, 0, 0, 32'h80000040, 1, 32'h800,     0, 1, 1, 32'h8000012C);
    add(0, 0, 12'h342, 0,            0, 0, 0, 0,            0, 32'h8000000B, 0, 0, 0, 0);
    add(0, 0, 12'h341, 0,            0, 0, 0, 0,            0, 32'h80000040, 0, 0, 0, 0);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            0, 32'h1880,     0, 0, 0, 0);
    add(1, 1, 12'h305, 32'h80000100, 0, 0, 0, 0,            0, 32'h80000101, 0, 0, 0, 0);
    add(1, 2, 12'h300, 32'h8,        0, 0, 0, 0,            0, 32'h1880,     0, 0, 0, 0);
    add(1, 0, 12'h000, 0,            0, 1, 0, 32'h80000010, 0, 0,            0, 1, 1, 32'h80000100);
    add(0, 0, 12'h341, 0,            0, 0, 0, 0,            0, 32'h80000010, 0, 0, 0, 0);
    add(0, 0, 12'h342, 0,            0, 0, 0, 0,            0, 32'hB,        0, 0, 0, 0);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            0, 32'h1880,     0, 0, 0, 0);
    add(1, 0, 12'h300, 0,            0, 0, 1, 32'h80000200, 0, 32'h1880,     0, 0, 1, 32'h80000010);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            0, 32'h1888,     0, 0, 0, 0);
    add(1, 3, 12'h304, 32'h80,       0, 0, 0, 0,            0, 32'h880,      0, 0, 0, 0);
    add(1, 6, 12'h304, 0,            1, 0, 0, 0,            0, 32'h800,      0, 0, 0, 0);
    add(0, 0, 12'h304, 0,            0, 0, 0, 0,            0, 32'h800,      0, 0, 0, 0);
    add(1, 1, 12'h7C0, 32'h1234,     0, 0, 0, 0,            0, 0,            1, 0, 0, 0);
    add(0, 0, 12'h340, 0,            0, 0, 0, 0,            0, 0,            0, 0, 0, 0);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            1, 32'h1888,     0, 0, 0, 0);
    add(0, 0, 12'h344, 0,            0, 0, 0, 0,            1, 0,            0, 0, 0, 0);
    add(1, 1, 12'h7C0, 32'h55,       0, 0, 0, 32'h80000300, 1, 0,            1, 1, 1, 32'h80000100);
    add(0, 0, 12'h342, 0,            0, 0, 0, 0,            0, 32'h8000000B, 0, 0, 0, 0);
    add(0, 0, 12'h341, 0,            0, 0, 0, 0,            0, 32'h80000300, 0, 0, 0, 0);
    add(1, 1, 12'h344, 32'hFFFF,     0, 0, 0, 0,            0, 0,            0, 0, 0, 0);
    add(1, 1, 12'h341, 32'h1237,     0, 0, 0, 0,            0, 32'h80000300, 0, 0, 0, 0);
    add(0, 0, 12'h341, 0,            0, 0, 0, 0,            0, 32'h1234,     0, 0, 0, 0);
    add(1, 1, 12'h300, 32'hFFFFFFFF, 0, 0, 0, 0,            0, 32'h1880,     0, 0, 0, 0);
    add(0, 0, 12'h300, 0,            0, 0, 0, 0,            0, 32'h1888,     0, 0, 0, 0);

    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mstatus", csr_rdata, 32'h1800);
    chk("reset_redirect", {31'b0, redirect}, 0);
    chk("reset_trap", {31'b0, trap_taken}, 0);
    chk("reset_illegal", {31'b0, illegal}, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      valid = tbl[i].v; csr_op = tbl[i].op; csr_addr = tbl[i].a; csr_wsrc = tbl[i].w;
      src_zero = tbl[i].sz; ecall = tbl[i].ec; mret = tbl[i].mr; pc = tbl[i].p; irq_ext = tbl[i].ie;
      irq_timer = 0;
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].e_rd);
      chk($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, tbl[i].e_ill});
      chk($sformatf("vec%0d_trap", i), {31'b0, trap_taken}, {31'b0, tbl[i].e_trap});
      chk($sformatf("vec%0d_redirect", i), {31'b0, redirect}, {31'b0, tbl[i].e_red});
      chk($sformatf("vec%0d_rpc", i), redirect_pc, tbl[i].e_rpc);
    end

    // Reset dropped while an ecall is committing: nothing of that trap may survive.
    @(negedge clk);
    valid = 1; ecall = 1; pc = 32'h80000400; csr_op = 0; csr_addr = 12'h341;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mepc", csr_rdata, 0);
    csr_addr = 12'h300; #1; chk("arst_mstatus", csr_rdata, 32'h1800);
    csr_addr = 12'h342; #1; chk("arst_mcause", csr_rdata, 0);
    csr_addr = 12'h305; #1; chk("arst_mtvec", csr_rdata, 0);
    csr_addr = 12'h304; #1; chk("arst_mie", csr_rdata, 0);
    csr_addr = 12'h341;
    @(posedge clk); #1;
    chk("arst_hold_mepc", csr_rdata, 0);
    @(negedge clk);
    idle();
    rst = 1'b1;

    // Random traffic against the model, starting from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      valid    = ($urandom_range(0, 7) != 0);
      csr_op   = ops[$urandom_range(0, 6)];
      csr_addr = addrs[$urandom_range(0, 9)];
      if (csr_op[2])                      csr_wsrc = XLEN'($urandom_range(0, 31));
      else if ($urandom_range(0, 7) == 0) csr_wsrc = 0;
      else                                csr_wsrc = $urandom;
      src_zero = (csr_wsrc == 0);
      ecall    = ($urandom_range(0, 15) == 0);
      mret     = ($urandom_range(0, 15) == 0);
      pc       = $urandom & ~32'h3;
      if ($urandom_range(0, 9) == 0) irq_ext   = ~irq_ext;
      if ($urandom_range(0, 9) == 0) irq_timer = ~irq_timer;
      #1;
      m_eval(e_rd, e_ill, e_trap, e_red, e_rpc);
      chk("rnd_rdata", csr_rdata, e_rd);
      chk("rnd_illegal", {31'b0, illegal}, {31'b0, e_ill});
      chk("rnd_trap", {31'b0, trap_taken}, {31'b0, e_trap});
      chk("rnd_redirect", {31'b0, redirect}, {31'b0, e_red});
      chk("rnd_rpc", redirect_pc, e_rpc);
      @(posedge clk);
      m_commit();
    end

`ifdef CSR_COUNTERS_EN
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    csr_addr = 12'hB00; #1; chk("cnt_mcycle10", csr_rdata, 10);
    csr_addr = 12'hB02; #1; chk("cnt_minstret0", csr_rdata, 0);
    @(negedge clk);
    valid = 1; csr_op = 3'd1; csr_addr = 12'hB00; csr_wsrc = 32'hFFFFFFFF; src_zero = 0;
    @(negedge clk);
    idle();
    csr_addr = 12'hB80;
    @(negedge clk); #1;
    chk("cnt_mcycleh_carry", csr_rdata, 1);
    csr_addr = 12'hB00; #1; chk("cnt_mcycle_wrap", csr_rdata, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
